// File: rtl/aim65_ram_arbiter_pkg.sv
// rtl/aim65_ram_arbiter_pkg.sv - shared types and sizes for the AIM-65 RAM arbiter
package aim65_arb_pkg;

  localparam int AIM65_RAM_AW   = 15;
  localparam int AIM65_RAM_DW   = 8;
  localparam int ARB_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/aim65_ram_arbiter_sat_counter.sv
// rtl/aim65_ram_arbiter_sat_counter.sv - up counter that sticks at all-ones
module aim65_sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge cpu_clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/aim65_ram_arbiter.sv
// rtl/aim65_ram_arbiter.sv - shares system RAM between the 65C02 and a DMA port
// Optional statistics outputs (steal_cnt, dma_cnt) are built when AIM65_ARB_STATS_EN is defined.
module aim65_ram_arbiter
  import aim65_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = AIM65_RAM_AW,
  parameter int DATA_WIDTH = AIM65_RAM_DW,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  cpu_clk,
  input  logic                  reset,
  input  logic                  cpu_cs,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rdy,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  ram_cs,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef AIM65_ARB_STATS_EN
  ,
  output logic [15:0]           steal_cnt,
  output logic [15:0]           dma_cnt
`endif
);

  arb_state_t                state;
  logic [ARB_WAIT_CNT_W-1:0] wait_cnt;
  logic                      grant;
  logic                      cpu_sel_q;
  logic [DATA_WIDTH-1:0]     cpu_hold_q;
  logic [DATA_WIDTH-1:0]     dma_rdata_q;

  // A waiting request takes any cycle the CPU leaves free, and steals once it has waited long enough.
  assign grant = (state == ARB_WAIT) &&
                 (!cpu_cs || (wait_cnt >= ARB_WAIT_CNT_W'(MAX_WAIT)));

  assign ram_cs   = grant ? 1'b1      : cpu_cs;
  assign ram_rw   = grant ? ~dma_we   : cpu_rw;
  assign ram_addr = grant ? dma_addr  : cpu_addr;
  assign ram_din  = grant ? dma_wdata : cpu_wdata;

  assign cpu_rdy   = ~(grant & cpu_cs);
  assign cpu_rdata = cpu_sel_q ? ram_dout : cpu_hold_q;
  assign dma_rdata = ((state == ARB_ACK) && !dma_we) ? ram_dout : dma_rdata_q;

  aim65_sat_counter #(.WIDTH(ARB_WAIT_CNT_W)) u_wait_cnt (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .inc     ((state == ARB_WAIT) && !grant),
    .clr     (state == ARB_IDLE),
    .count   (wait_cnt)
  );

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      dma_ack     <= 1'b0;
      dma_rdata_q <= '0;
      cpu_sel_q   <= 1'b0;
      cpu_hold_q  <= '0;
    end else begin
      dma_ack <= 1'b0;
      case (state)
        ARB_IDLE: if (dma_req) state <= ARB_WAIT;
        ARB_WAIT: if (grant) begin
          state   <= ARB_ACK;
          dma_ack <= 1'b1;
        end
        default:  state <= ARB_IDLE;
      endcase
      cpu_sel_q <= cpu_cs & cpu_rw & ~grant;
      if (cpu_sel_q) cpu_hold_q <= ram_dout;
      if ((state == ARB_ACK) && !dma_we) dma_rdata_q <= ram_dout;
    end
  end

`ifdef AIM65_ARB_STATS_EN
  aim65_sat_counter #(.WIDTH(16)) u_steal_cnt (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .inc     (~cpu_rdy),
    .clr     (1'b0),
    .count   (steal_cnt)
  );

  aim65_sat_counter #(.WIDTH(16)) u_dma_cnt (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .inc     (dma_ack),
    .clr     (1'b0),
    .count   (dma_cnt)
  );
`endif

endmodule

// File: tb/tb_aim65_ram_arbiter.sv
// tb/tb_aim65_ram_arbiter.sv - self-checking bench for aim65_ram_arbiter
module tb_aim65_ram_arbiter;

  logic        cpu_clk, reset;
  logic        cpu_cs, cpu_rw, cpu_rdy;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [14:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        ram_cs, ram_rw;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
`ifdef AIM65_ARB_STATS_EN
  logic [15:0] steal_cnt, dma_cnt;
`endif

  aim65_ram_arbiter dut (
    .cpu_clk(cpu_clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
`ifdef AIM65_ARB_STATS_EN
    , .steal_cnt(steal_cnt), .dma_cnt(dma_cnt)
`endif
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Single-port synchronous RAM, one cycle read latency
  logic [7:0] mem [0:32767];
  always @(posedge cpu_clk) begin
    if (ram_cs) begin
      if (!ram_rw) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [7:0]  data;
  } dma_exp_t;

  typedef struct {
    bit          busy;
    bit          we;
    logic [14:0] addr;
    logic [7:0]  data;
    int          lat;
    int          stalls;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  dma_exp_t    dma_q[$];
  logic [7:0]  cpu_q[$];
  logic [7:0]  shadow [logic [14:0]];
  logic [7:0]  last_cpu = 8'h00;
  logic [7:0]  last_dma = 8'h00;
  bit          rd_pend = 1'b0;
  bit          ack_seen, stall_seen;
  logic        s_cs, s_rw;
  logic [14:0] s_addr;
  vec_t        vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] shadow_rd(input logic [14:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  // One clock cycle: sample mid-cycle, run the scoreboard, advance to just after the next edge.
  task automatic tick();
    dma_exp_t e;
    ack_seen = 1'b0;
    stall_seen = 1'b0;
    #4;
    s_cs = ram_cs; s_rw = ram_rw; s_addr = ram_addr;
    if (rd_pend) last_cpu = cpu_q.pop_front();
    check("cpu_rdata", 32'(cpu_rdata), 32'(last_cpu));
    if (dma_ack) begin
      ack_seen = 1'b1;
      if (dma_q.size() == 0) begin
        check("dma_ack_unexpected", 32'(dma_ack), 32'(0));
      end else begin
        e = dma_q.pop_front();
        if (e.we) shadow[e.addr] = e.data;
        else last_dma = e.data;
      end
    end
    check("dma_rdata", 32'(dma_rdata), 32'(last_dma));
    if (!cpu_rdy) stall_seen = 1'b1;
    rd_pend = cpu_cs && cpu_rw && cpu_rdy && !reset;
    if (rd_pend) cpu_q.push_back(shadow_rd(cpu_addr));
    if (cpu_cs && !cpu_rw && cpu_rdy) shadow[cpu_addr] = cpu_wdata;
    if (reset) begin
      rd_pend = 1'b0; last_cpu = 8'h00; last_dma = 8'h00;
      cpu_q.delete(); dma_q.delete();
    end
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic start_dma(input bit we, input logic [14:0] a, input logic [7:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    dma_q.push_back('{we, a, we ? d : shadow_rd(a)});
  endtask

  task automatic run_dma(input vec_t v);
    int lat, st, stall_k;
    lat = -1; st = 0; stall_k = -1;
    start_dma(v.we, v.addr, v.data);
    cpu_cs = v.busy; cpu_rw = 1'b1; cpu_addr = 15'h0200;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      tick();
      if (stall_seen) begin st++; stall_k = k; end
      if (!v.busy && k == 1) check("dma_fields_on_ram", 32'({s_cs, s_rw, s_addr}), 32'({1'b1, ~v.we, v.addr}));
      if (ack_seen) begin lat = k; dma_req = 1'b0; cpu_cs = 1'b0; end
    end
    dma_req = 1'b0; cpu_cs = 1'b0;
    check("dma_latency", 32'(lat), 32'(v.lat));
    check("steal_count", 32'(st), 32'(v.stalls));
    if (v.busy) check("steal_position", 32'(stall_k), 32'(v.lat - 1));
    tick(); tick();
  endtask

  initial begin
    int st, n, viol, lat;
    bit prev_st;

    vecs[0] = '{1'b0, 1'b1, 15'h0200, 8'hA5, 2, 0};
    vecs[1] = '{1'b0, 1'b1, 15'h7FFF, 8'h3C, 2, 0};
    vecs[2] = '{1'b0, 1'b0, 15'h0200, 8'h00, 2, 0};
    vecs[3] = '{1'b1, 1'b0, 15'h7FFF, 8'h00, 6, 1};
    vecs[4] = '{1'b1, 1'b1, 15'h0300, 8'h5A, 6, 1};
    vecs[5] = '{1'b0, 1'b0, 15'h0300, 8'h00, 2, 0};

    reset = 1'b1; cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'h77;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 15'h0000; dma_wdata = 8'h00;
    repeat (2) @(posedge cpu_clk);
    #5;
    check("rst_cpu_rdy", 32'(cpu_rdy), 32'(1));
    check("rst_dma_ack", 32'(dma_ack), 32'(0));
    check("rst_dma_rdata", 32'(dma_rdata), 32'(0));
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    check("rst_ram_pass", 32'({ram_cs, ram_rw, ram_addr, ram_din}), 32'({1'b1, 1'b1, 15'h1234, 8'h77}));
    @(posedge cpu_clk);
    #1;
    reset = 1'b0; cpu_cs = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_dma(vecs[i]);

    // CPU write colliding with a DMA write to the same address
    start_dma(1'b1, 15'h0010, 8'h22);
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h0200;
    st = 0; lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (k == 5) begin cpu_rw = 1'b0; cpu_addr = 15'h0010; cpu_wdata = 8'h11; end
      tick();
      if (stall_seen) begin st++; check("ram_after_steal", 32'(mem[15'h0010]), 32'(8'h22)); end
      if (ack_seen) begin
        lat = k; dma_req = 1'b0; cpu_cs = 1'b0;
        check("ram_after_cpu_write", 32'(mem[15'h0010]), 32'(8'h11));
      end
    end
    check("collide_stalls", 32'(st), 32'(1));
    check("collide_latency", 32'(lat), 32'(6));
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h0010;
    tick();
    cpu_cs = 1'b0;
    tick(); tick();

    // Four back-to-back DMA reads with the CPU hammering RAM
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h7FFF;
    for (int i = 0; i < 4; i++) dma_q.push_back('{1'b0, 15'h7FFF, 8'h3C});
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h0200;
    st = 0; n = 0; viol = 0; prev_st = 1'b0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      tick();
      if (stall_seen) begin st++; if (prev_st) viol++; end
      prev_st = stall_seen;
      if (ack_seen) n++;
      if (n == 4) begin dma_req = 1'b0; cpu_cs = 1'b0; end
    end
    check("b2b_acks", 32'(n), 32'(4));
    check("b2b_steals", 32'(st), 32'(4));
    check("b2b_consecutive_stalls", 32'(viol), 32'(0));
    dma_req = 1'b0; cpu_cs = 1'b0;
    tick(); tick();

    // Reset while waiting with wait_cnt=3
    start_dma(1'b0, 15'h7FFF, 8'h00);
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h0200;
    st = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) reset = 1'b1;
      tick();
      if (stall_seen) st++;
    end
    reset = 1'b0; dma_req = 1'b0;
    check("pre_reset_stalls", 32'(st), 32'(0));
    n = 0; st = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack_seen) n++;
      if (stall_seen) st++;
    end
    check("post_reset_no_ack", 32'(n), 32'(0));
    check("post_reset_rdy", 32'(st), 32'(0));
    cpu_cs = 1'b0;
    tick();
    run_dma('{1'b0, 1'b0, 15'h0200, 8'h00, 2, 0});

    // Three steals and two free-cycle transfers from a clean reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) run_dma('{1'b1, 1'b0, 15'h7FFF, 8'h00, 6, 1});
    run_dma('{1'b0, 1'b1, 15'h0400, 8'h96, 2, 0});
    run_dma('{1'b0, 1'b0, 15'h0400, 8'h00, 2, 0});
`ifdef AIM65_ARB_STATS_EN
    check("steal_cnt", 32'(steal_cnt), 32'(3));
    check("dma_cnt", 32'(dma_cnt), 32'(5));
`endif
    check("dma_queue_drained", 32'(dma_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
